// File: rtl/cordic_pkg.sv
// Shared types for the CORDIC range-reduction wrapper: FSM states and
// quadrant encodings of the full-circle phase word.
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        OUT    = 2'd3
    } state_t;

    typedef logic [1:0] quad_t;

    localparam quad_t Q0 = 2'd0;
    localparam quad_t Q1 = 2'd1;
    localparam quad_t Q2 = 2'd2;
    localparam quad_t Q3 = 2'd3;

endpackage : cordic_pkg

// File: rtl/cordic_quadrant_map.sv
// Maps first-quadrant core magnitudes (x = cos, y = sin) back to the full
// circle as signed results, using the quadrant of the original phase.
module cordic_quadrant_map
    import cordic_pkg::*;
#(
    parameter int BIT_WIDTH = 16
) (
    input  quad_t                i_quad,
    input  logic [BIT_WIDTH-1:0] i_x,
    input  logic [BIT_WIDTH-1:0] i_y,
    output logic [BIT_WIDTH:0]   o_cos,
    output logic [BIT_WIDTH:0]   o_sin
);

    // One extra bit of headroom: a zero-extended magnitude always has a
    // representable two's-complement negation.
    logic [BIT_WIDTH:0] w_x_pos;
    logic [BIT_WIDTH:0] w_y_pos;
    logic [BIT_WIDTH:0] w_x_neg;
    logic [BIT_WIDTH:0] w_y_neg;

    assign w_x_pos = {1'b0, i_x};
    assign w_y_pos = {1'b0, i_y};
    assign w_x_neg = -w_x_pos;
    assign w_y_neg = -w_y_pos;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        o_cos = w_x_pos;
        o_sin = w_y_pos;
        case (i_quad)
            Q0: begin
                o_cos = w_x_pos;
                o_sin = w_y_pos;
            end
            Q1: begin
                o_cos = w_y_neg;
                o_sin = w_x_pos;
            end
            Q2: begin
                o_cos = w_x_neg;
                o_sin = w_y_neg;
            end
            Q3: begin
                o_cos = w_y_pos;
                o_sin = w_x_neg;
            end
            default: begin
                o_cos = w_x_pos;
                o_sin = w_y_pos;
            end
        endcase
    end

endmodule : cordic_quadrant_map

// File: rtl/cordic_range_reduce.sv
// Folds a full-circle phase into the first quadrant, launches an external
// CORDIC core on the offset, and sign-maps its magnitudes to cos/sin.
module cordic_range_reduce
    import cordic_pkg::*;
#(
    parameter int BIT_WIDTH = 16,
    parameter int K         = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH+1:0] in_phase,

    output logic                 core_start,
    output logic [BIT_WIDTH-1:0] core_target,
    input  logic                 core_done,
    input  logic [BIT_WIDTH-1:0] core_x,
    input  logic [BIT_WIDTH-1:0] core_y,

    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH:0]   out_cos,
    output logic [BIT_WIDTH:0]   out_sin
);

    // K belongs to the core; it is only sanity-checked here.
    if (BIT_WIDTH < 2 || K < 0) begin : g_param_check
        $error("cordic_range_reduce: BIT_WIDTH must be >= 2 and K non-negative");
    end

    state_t               r_state;
    state_t               w_next_state;
    quad_t                r_quad;
    logic [BIT_WIDTH-1:0] r_offset;
    logic [BIT_WIDTH:0]   r_cos;
    logic [BIT_WIDTH:0]   r_sin;

    logic                 w_accept;
    logic                 w_capture;
    logic [BIT_WIDTH:0]   w_map_cos;
    logic [BIT_WIDTH:0]   w_map_sin;

    cordic_quadrant_map #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_quadrant_map (
        .i_quad (r_quad),
        .i_x    (core_x),
        .i_y    (core_y),
        .o_cos  (w_map_cos),
        .o_sin  (w_map_sin)
    );

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        core_start   = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = LAUNCH;
                end
            end
            LAUNCH: begin
                core_start   = 1'b1;
                w_next_state = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    w_next_state = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    w_next_state = in_valid ? LAUNCH : IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign w_accept  = in_valid && in_ready;
    assign w_capture = (r_state == WAIT) && core_done;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Offset is only reloaded on acceptance, which holds the core target
    // steady through LAUNCH and WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quad   <= Q0;
            r_offset <= '0;
        end else if (w_accept) begin
            r_quad   <= in_phase[BIT_WIDTH+1:BIT_WIDTH];
            r_offset <= in_phase[BIT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cos <= '0;
            r_sin <= '0;
        end else if (w_capture) begin
            r_cos <= w_map_cos;
            r_sin <= w_map_sin;
        end
    end

    assign core_target = r_offset;
    assign out_cos     = r_cos;
    assign out_sin     = r_sin;

endmodule : cordic_range_reduce

// File: tb/tb_cordic_range_reduce.sv
// Directed bench for cordic_range_reduce with a behavioural core responder
// and an expected-result queue drained on each output handshake.
module tb_cordic_range_reduce;
    import cordic_pkg::*;

    localparam int BW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid;
    logic          in_ready;
    logic [BW+1:0] in_phase;
    logic          core_start;
    logic [BW-1:0] core_target;
    logic          core_done = 1'b0;
    logic [BW-1:0] core_x = '0;
    logic [BW-1:0] core_y = '0;
    logic          out_valid;
    logic          out_ready;
    logic [BW:0]   out_cos;
    logic [BW:0]   out_sin;

    int n_checks = 0;
    int n_errors = 0;
    int n_xfers  = 0;

    typedef struct {
        logic [BW:0] c;
        logic [BW:0] s;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [BW+1:0] phase;
        logic [BW-1:0] x;
        logic [BW-1:0] y;
        logic [BW:0]   c;
        logic [BW:0]   s;
        logic [BW-1:0] target;
    } vec_t;

    logic [BW-1:0] m_x = '0;
    logic [BW-1:0] m_y = '0;
    logic          rsp_busy = 1'b0;
    int            rsp_cnt = 0;

    always #5 clk = ~clk;

    cordic_range_reduce #(
        .BIT_WIDTH (BW),
        .K         (0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_phase    (in_phase),
        .core_start  (core_start),
        .core_target (core_target),
        .core_done   (core_done),
        .core_x      (core_x),
        .core_y      (core_y),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_cos     (out_cos),
        .out_sin     (out_sin)
    );

    // Core model: done rises 20 cycles after the start pulse and is held.
    always @(posedge clk) begin
        if (core_start === 1'b1) begin
            core_done <= 1'b0;
            rsp_busy  <= 1'b1;
            rsp_cnt   <= 1;
        end else if (rsp_busy) begin
            if (rsp_cnt == 19) begin
                core_done <= 1'b1;
                core_x    <= m_x;
                core_y    <= m_y;
                rsp_busy  <= 1'b0;
            end else begin
                rsp_cnt <= rsp_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every output handshake must match the oldest entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_xfers++;
            n_checks++;
            assert (sb.size() != 0) else begin
                n_errors++;
                $error("FAIL unexpected_output: observed cos=0x%0h sin=0x%0h, required no output",
                       out_cos, out_sin);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("out_cos", 32'(out_cos), 32'(e.c));
                check("out_sin", 32'(out_sin), 32'(e.s));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a phase from IDLE, checks the start pulse lands one cycle after
    // acceptance and lasts one cycle, and leaves the DUT in WAIT.
    task automatic send(input vec_t v, input bit push);
        int waited;
        m_x = v.x;
        m_y = v.y;
        if (push) sb.push_back('{c: v.c, s: v.s});
        in_phase = v.phase;
        in_valid = 1'b1;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("start_latency", 32'(core_start), 32'd1);
        check("core_target", 32'(core_target), 32'(v.target));
        check("busy_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("start_width", 32'(core_start), 32'd0);
        check("target_stable", 32'(core_target), 32'(v.target));
    endtask

    task automatic wait_out();
        logic pd;
        logic ppd;
        bit   got;
        pd  = 1'b0;
        ppd = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (out_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            ppd = pd;
            pd  = core_done;
            tick();
        end
        check("out_timeout", 32'(got), 32'd1);
        if (got) check("done_to_valid", 32'({ppd, pd}), 32'b01);
    endtask

    vec_t vecs[5] = '{
        '{phase: 18'h00000, x: 16'h9B74, y: 16'h0000, c: 17'h09B74, s: 17'h00000, target: 16'h0000},
        '{phase: 18'h14000, x: 16'h6000, y: 16'h8000, c: 17'h18000, s: 17'h06000, target: 16'h4000},
        '{phase: 18'h2C000, x: 16'h3000, y: 16'h7000, c: 17'h1D000, s: 17'h19000, target: 16'hC000},
        '{phase: 18'h3ABCD, x: 16'h1234, y: 16'hFFFF, c: 17'h0FFFF, s: 17'h1EDCC, target: 16'hABCD},
        '{phase: 18'h20000, x: 16'h0000, y: 16'h0000, c: 17'h00000, s: 17'h00000, target: 16'h0000}
    };

    initial begin
        vec_t v;
        int   base;

        in_valid  = 1'b0;
        in_phase  = '0;
        out_ready = 1'b1;

        // Asynchronous reset, checked before any clock edge reaches the DUT.
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_core_start", 32'(core_start), 32'd0);
        check("rst_out_cos", 32'(out_cos), 32'd0);
        check("rst_out_sin", 32'(out_sin), 32'd0);
        check("rst_core_target", 32'(core_target), 32'd0);
        check("rst_quad", 32'(dut.r_quad), 32'd0);
        check("rst_state", 32'(dut.r_state), 32'(IDLE));
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // One transaction per quadrant plus zero offsets and full-scale magnitudes.
        foreach (vecs[i]) begin
            send(vecs[i], 1'b1);
            wait_out();
            tick();
            check("out_drop", 32'(out_valid), 32'd0);
        end

        // Backpressure: result must hold for five cycles and transfer once.
        out_ready = 1'b0;
        v = '{phase: 18'h10001, x: 16'hFFFF, y: 16'hFFFF, c: 17'h10001, s: 17'h0FFFF, target: 16'h0001};
        send(v, 1'b1);
        wait_out();
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_cos", 32'(out_cos), 32'(v.c));
            check("bp_sin", 32'(out_sin), 32'(v.s));
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_core_start", 32'(core_start), 32'd0);
            tick();
        end
        base = n_xfers;
        out_ready = 1'b1;
        tick();
        check("bp_one_xfer", 32'(n_xfers), 32'(base + 1));
        check("bp_valid_drop", 32'(out_valid), 32'd0);
        tick();
        check("bp_no_repeat", 32'(n_xfers), 32'(base + 1));

        // Back-to-back: a new phase accepted during the output handshake.
        v = '{phase: 18'h05555, x: 16'h1111, y: 16'h2222, c: 17'h01111, s: 17'h02222, target: 16'h5555};
        send(v, 1'b1);
        wait_out();
        m_x = 16'hAAAA;
        m_y = 16'h5555;
        sb.push_back('{c: 17'h05555, s: 17'h15556});
        check("b2b_in_ready", 32'(in_ready), 32'd1);
        in_phase = 18'h38000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("b2b_start", 32'(core_start), 32'd1);
        check("b2b_state", 32'(dut.r_state), 32'(LAUNCH));
        check("b2b_target", 32'(core_target), 32'h8000);
        check("b2b_valid_drop", 32'(out_valid), 32'd0);
        tick();
        wait_out();
        tick();

        // Reset ten cycles into WAIT; the later core_done must be ignored.
        v = '{phase: 18'h12345, x: 16'h0001, y: 16'h0002, c: 17'h00000, s: 17'h00000, target: 16'h2345};
        send(v, 1'b0);
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        check("wrst_state", 32'(dut.r_state), 32'(IDLE));
        check("wrst_in_ready", 32'(in_ready), 32'd1);
        check("wrst_out_valid", 32'(out_valid), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 40 && core_done !== 1'b1; k++) tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            check("stale_out_valid", 32'(out_valid), 32'd0);
            check("stale_state", 32'(dut.r_state), 32'(IDLE));
            check("stale_in_ready", 32'(in_ready), 32'd1);
            check("stale_core_start", 32'(core_start), 32'd0);
        end

        // Recovery with a zero offset in quadrant 1.
        v = '{phase: 18'h10000, x: 16'h4000, y: 16'h0000, c: 17'h00000, s: 17'h04000, target: 16'h0000};
        send(v, 1'b1);
        wait_out();
        tick();
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_cordic_range_reduce
